fifo_msg_assembler: RTL

Read-side consumer of the byte FIFO. It pops characters one at a time, assembles them into a message, and presents the complete message to a downstream consumer with a valid/ready handshake. A message ends at a terminator byte (newline 0x0A or NUL 0x00) or when MAX_LEN bytes have been collected. It runs entirely in the FIFO read clock domain.

---
 rtl/fifo_msg_pkg.sv | 18 +
 rtl/fifo_msg_assembler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo_msg_pkg.sv
// Shared definitions for the FIFO message assembler: terminators and FSM states.
package fifo_msg_pkg;

    localparam logic [7:0] TERM_NL  = 8'h0A;
    localparam logic [7:0] TERM_NUL = 8'h00;

    typedef enum logic [1:0] {
        S_REQ,
        S_CAP,
        S_DONE
    } msg_state_t;

    // A byte closes the current message when it is a newline or NUL.
    function automatic logic is_term(input logic [7:0] b);
        return (b == TERM_NL) || (b == TERM_NUL);
    endfunction

endpackage

// File: rtl/fifo_msg_assembler.sv
// Pops bytes from the read side of a byte FIFO, assembles them into a message
// closed by a terminator or by MAX_LEN bytes, and offers it downstream with valid/ready.
module fifo_msg_assembler
    import fifo_msg_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 50,
    parameter bit          DROP_EMPTY = 1'b1,
    localparam int unsigned LenW      = $clog2(MAX_LEN + 1)
) (
    input  logic                   read_clk_i,
    input  logic                   rst_ni,
    input  logic                   fifo_empty_i,
    input  logic [7:0]             fifo_data_i,
    output logic                   fifo_rd_en_o,
    output logic                   msg_valid_o,
    input  logic                   msg_ready_i,
    output logic [MAX_LEN*8-1:0]   msg_data_o,
    output logic [LenW-1:0]        msg_len_o,
    output logic                   msg_trunc_o
);

    msg_state_t      state_q, state_d;
    logic [LenW-1:0] len_q, len_d;
    logic            trunc_q, trunc_d;
    logic [7:0]      buf_q [MAX_LEN];
    logic            buf_we;
    logic            cap_term;

    // Only one pop can be in flight: popping moves us to S_CAP, which never pops.
    assign fifo_rd_en_o = (state_q == S_REQ) && !fifo_empty_i;
    assign cap_term     = is_term(fifo_data_i);

    assign msg_valid_o = (state_q == S_DONE);
    assign msg_len_o   = len_q;
    assign msg_trunc_o = trunc_q;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign msg_data_o[8*g +: 8] = buf_q[g];
    end

    // Next-state logic: request, capture, then hold the message until accepted.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        buf_we  = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (!fifo_empty_i) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                if (cap_term) begin
                    if ((len_q == '0) && DROP_EMPTY) begin
                        state_d = S_REQ;
                    end else begin
                        trunc_d = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    buf_we = 1'b1;
                    len_d  = len_q + 1'b1;
                    // A full buffer closes the message before any further write.
                    if (len_d == LenW'(MAX_LEN)) begin
                        trunc_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                if (msg_ready_i) begin
                    len_d   = '0;
                    trunc_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State, length and truncation flag registers.
    always_ff @(posedge read_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_REQ;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

    // Payload buffer: the captured byte lands at the current length index.
    always_ff @(posedge read_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (len_q == LenW'(i)) begin
                    buf_q[i] <= fifo_data_i;
                end
            end
        end
    end

`ifndef SYNTHESIS
    len_bound_a: assert property (@(posedge read_clk_i) disable iff (!rst_ni)
        len_q <= LenW'(MAX_LEN));
    no_pop_in_done_a: assert property (@(posedge read_clk_i) disable iff (!rst_ni)
        (state_q == S_DONE) |-> !fifo_rd_en_o);
`endif

endmodule
